// File: rtl/f32_divmean_unit.sv
`default_nettype none
// ============================================================================
// Module   : f32_divmean_unit
// Purpose  : Single-precision divide (restoring, 26 quotient bits) and
//            two-operand mean, plus a combinational 8-bit exponent adder.
// Revision : 1.0  initial release
// ============================================================================
module f32_divmean_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        rdy,
    output logic [31:0] result,
    input  logic [7:0]  add_a,
    input  logic [7:0]  add_b,
    input  logic        add_cin,
    output logic [7:0]  add_sum
);
    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UNPACK   = 3'd1,
        S_DIV_ITER = 3'd2,
        S_ADD      = 3'd3,
        S_NORM     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d, rdy_q, rdy_d, sign_q, sign_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [31:0]        a_q, a_d, b_q, b_d, pack_q, pack_d, result_q, result_d;
    logic [7:0]         ea_q, ea_d, eb_q, eb_d;
    logic [23:0]        ma_q, ma_d, mb_q, mb_d;
    logic signed [9:0]  exp_q, exp_d;
    logic [25:0]        quo_q, quo_d, rem_q, rem_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [27:0]        sum_q, sum_d;

    // Operand decode straight from the captured words (used in UNPACK)
    logic [7:0]         w_ea, w_eb;
    logic [23:0]        w_ma, w_mb;
    logic               w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sdiv;
    logic signed [9:0]  w_ebase;
    logic               w_spec;
    logic [31:0]        w_spec_res;

    assign w_ea     = a_q[30:23];
    assign w_eb     = b_q[30:23];
    assign w_a_zero = (w_ea == 8'd0);
    assign w_b_zero = (w_eb == 8'd0);
    assign w_ma     = w_a_zero ? 24'd0 : {1'b1, a_q[22:0]};
    assign w_mb     = w_b_zero ? 24'd0 : {1'b1, b_q[22:0]};
    assign w_a_nan  = (w_ea == 8'hFF) && (a_q[22:0] != 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (b_q[22:0] != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (a_q[22:0] == 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (b_q[22:0] == 23'd0);
    assign w_sdiv   = a_q[31] ^ b_q[31];
    assign w_ebase  = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127;

    // Quotients whose exponent is out of range whatever the mantissas resolve early
    always_comb begin
        w_spec     = 1'b1;
        w_spec_res = C_QNAN;
        if (!op_q) begin
            if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
                w_spec_res = C_QNAN;
            else if (w_a_inf || w_b_zero || (w_ebase >= 10'sd256))
                w_spec_res = {w_sdiv, 8'hFF, 23'd0};
            else if (w_a_zero || w_b_inf || (w_ebase < 10'sd0))
                w_spec_res = {w_sdiv, 31'd0};
            else
                w_spec = 1'b0;
        end else begin
            if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (a_q[31] != b_q[31])))
                w_spec_res = C_QNAN;
            else if (w_a_inf)
                w_spec_res = {a_q[31], 8'hFF, 23'd0};
            else if (w_b_inf)
                w_spec_res = {b_q[31], 8'hFF, 23'd0};
            else
                w_spec = 1'b0;
        end
    end

    // Mean alignment: three extra bits below the mantissa act as guard/round/sticky
    logic        w_a_big;
    logic [7:0]  w_e_big, w_dexp;
    logic [26:0] w_ext_b, w_ext_s, w_lost, w_small;
    logic [27:0] w_sum;

    assign w_a_big = {ea_q, ma_q} >= {eb_q, mb_q};
    assign w_e_big = w_a_big ? ea_q : eb_q;
    assign w_dexp  = w_a_big ? (ea_q - eb_q) : (eb_q - ea_q);
    assign w_ext_b = w_a_big ? {ma_q, 3'b000} : {mb_q, 3'b000};
    assign w_ext_s = w_a_big ? {mb_q, 3'b000} : {ma_q, 3'b000};
    assign w_lost  = w_ext_s & ~({27{1'b1}} << w_dexp);
    assign w_small = (w_ext_s >> w_dexp) | {26'd0, |w_lost};
    assign w_sum   = (sa_q == sb_q) ? ({1'b0, w_ext_b} + {1'b0, w_small})
                                    : ({1'b0, w_ext_b} - {1'b0, w_small});

    // Normalise to an implicit leading one, then round to nearest even and pack
    logic [25:0]       w_n;
    logic signed [9:0] w_e, w_er;
    logic              w_zero, w_up;
    logic [4:0]        w_msb, w_sh;
    logic [23:0]       w_fr;
    logic [31:0]       w_pack;

    always_comb begin
        w_n    = 26'd0;
        w_e    = exp_q;
        w_zero = 1'b0;
        w_sh   = 5'd0;
        w_msb  = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum_q[i]) w_msb = i[4:0];
        if (!op_q) begin
            if (quo_q[25]) begin
                w_n = {quo_q[24:0], |rem_q};
            end else begin
                w_n = {quo_q[23:0], 1'b0, |rem_q};
                w_e = exp_q - 10'sd1;
            end
        end else begin
            if (sum_q == 28'd0) begin
                w_zero = 1'b1;
            end else if (sum_q[27]) begin
                w_n = {sum_q[26:2], |sum_q[1:0]};
                w_e = exp_q;
            end else begin
                w_sh = 5'd26 - w_msb;
                w_n  = sum_q[25:0] << w_sh;
                w_e  = exp_q - $signed({5'd0, w_sh}) - 10'sd1;
            end
        end
        w_up = w_n[2] & (w_n[1] | w_n[0] | w_n[3]);
        w_fr = {1'b0, w_n[25:3]} + {23'd0, w_up};
        w_er = w_fr[23] ? (w_e + 10'sd1) : w_e;
        if (w_zero)
            w_pack = 32'd0;
        else if (w_er >= 10'sd255)
            w_pack = {sign_q, 8'hFF, 23'd0};
        else if (w_er <= 10'sd0)
            w_pack = {sign_q, 31'd0};
        else
            w_pack = {sign_q, w_er[7:0], w_fr[22:0]};
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        rdy_d    = rdy_q;
        sign_d   = sign_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        ea_d     = ea_q;
        eb_d     = eb_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        exp_d    = exp_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        pack_d   = pack_q;
        result_d = result_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if ((state_q == S_DONE) && !rdy_q) begin
                    result_d = pack_q;
                    rdy_d    = 1'b1;
                end else if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    rdy_d   = 1'b0;
                    state_d = S_UNPACK;
                end
            end
            S_UNPACK: begin
                sa_d   = a_q[31];
                sb_d   = b_q[31];
                ea_d   = w_ea;
                eb_d   = w_eb;
                ma_d   = w_ma;
                mb_d   = w_mb;
                sign_d = w_sdiv;
                exp_d  = w_ebase;
                rem_d  = {2'b00, w_ma};
                quo_d  = 26'd0;
                cnt_d  = 5'd0;
                if (w_spec) begin
                    pack_d  = w_spec_res;
                    state_d = S_DONE;
                end else begin
                    state_d = op_q ? S_ADD : S_DIV_ITER;
                end
            end
            S_DIV_ITER: begin
                if (rem_q >= {2'b00, mb_q}) begin
                    quo_d = {quo_q[24:0], 1'b1};
                    rem_d = (rem_q - {2'b00, mb_q}) << 1;
                end else begin
                    quo_d = {quo_q[24:0], 1'b0};
                    rem_d = rem_q << 1;
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd25) state_d = S_NORM;
            end
            S_ADD: begin
                sum_d   = w_sum;
                exp_d   = $signed({2'b00, w_e_big});
                sign_d  = w_a_big ? sa_q : sb_q;
                state_d = S_NORM;
            end
            S_NORM: begin
                pack_d  = w_pack;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= 1'b0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            rdy_q    <= 1'b0;
            sign_q   <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            ea_q     <= 8'd0;
            eb_q     <= 8'd0;
            ma_q     <= 24'd0;
            mb_q     <= 24'd0;
            exp_q    <= 10'sd0;
            quo_q    <= 26'd0;
            rem_q    <= 26'd0;
            cnt_q    <= 5'd0;
            sum_q    <= 28'd0;
            pack_q   <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rdy_q    <= rdy_d;
            sign_q   <= sign_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            ea_q     <= ea_d;
            eb_q     <= eb_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            exp_q    <= exp_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            pack_q   <= pack_d;
            result_q <= result_d;
        end
    end

    assign rdy     = rdy_q;
    assign result  = result_q;
    assign add_sum = add_a + add_b + {7'd0, add_cin};

endmodule
`default_nettype wire

// File: tb/tb_f32_divmean_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_f32_divmean_unit
// Purpose  : Directed-vector bench for f32_divmean_unit.
// Revision : 1.0  initial release
// ============================================================================
module tb_f32_divmean_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        rdy;
    logic [31:0] result;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;

    int n_chk = 0;
    int n_err = 0;

    f32_divmean_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .rdy     (rdy),
        .result  (result),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_sum (add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        int          lat;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
    } add_vec_t;

    vec_t     tbl  [25];
    add_vec_t atbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Launch one operation and measure the edge count from acceptance to rdy
    task automatic run_op(input string nm, input logic o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_r, input int exp_lat);
        int lat;
        lat = 0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom();
        b     = $urandom();
        chk({nm, " rdy low after accept"}, 32'(rdy), 32'd0);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (rdy) lat = n;
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " result"}, result, exp_r);
    endtask

    initial begin
        int lat;
        tbl[0]  = '{1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 29};
        tbl[1]  = '{1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29};
        tbl[2]  = '{1'b0, 32'hC0C00000, 32'h40000000, 32'hC0400000, 29};
        tbl[3]  = '{1'b0, 32'h3F800000, 32'h00000000, 32'h7F800000, 2};
        tbl[4]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 2};
        tbl[5]  = '{1'b0, 32'h7F7FFFFF, 32'h00800000, 32'h7F800000, 2};
        tbl[6]  = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2};
        tbl[7]  = '{1'b0, 32'h80000000, 32'h40A00000, 32'h80000000, 2};
        tbl[8]  = '{1'b0, 32'h7F800000, 32'h40000000, 32'h7F800000, 2};
        tbl[9]  = '{1'b0, 32'h3F800000, 32'hFF800000, 32'h80000000, 2};
        tbl[10] = '{1'b0, 32'h00800000, 32'h40000000, 32'h00000000, 29};
        tbl[11] = '{1'b0, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 2};
        tbl[12] = '{1'b1, 32'h40000000, 32'h40800000, 32'h40400000, 4};
        tbl[13] = '{1'b1, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F7FFFFF, 4};
        tbl[14] = '{1'b1, 32'h3F800000, 32'hBF800000, 32'h00000000, 4};
        tbl[15] = '{1'b1, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 2};
        tbl[16] = '{1'b1, 32'h7F800000, 32'h3F800000, 32'h7F800000, 2};
        tbl[17] = '{1'b1, 32'h3F800000, 32'h00000000, 32'h3F000000, 4};
        tbl[18] = '{1'b1, 32'h3F800000, 32'h33800000, 32'h3F000000, 4};
        tbl[19] = '{1'b1, 32'h3F800000, 32'h34400000, 32'h3F000002, 4};
        tbl[20] = '{1'b1, 32'h00000001, 32'h00000001, 32'h00000000, 4};
        tbl[21] = '{1'b1, 32'h00800000, 32'h80000000, 32'h00000000, 4};
        tbl[22] = '{1'b1, 32'hC0000000, 32'hC0800000, 32'hC0400000, 4};
        tbl[23] = '{1'b1, 32'h40800000, 32'hC0000000, 32'h3F800000, 4};
        tbl[24] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h3F800000, 29};

        atbl[0] = '{8'hC8, 8'h81, 1'b0, 8'h49};
        atbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00};
        atbl[2] = '{8'h7F, 8'h81, 1'b0, 8'h00};
        atbl[3] = '{8'h10, 8'h20, 1'b1, 8'h31};
        atbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF};

        rst     = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        a       = 32'd0;
        b       = 32'd0;
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        #12;
        chk("reset rdy", 32'(rdy), 32'd0);
        chk("reset result", result, 32'd0);

        for (int i = 0; i < 5; i++) begin
            add_a   = atbl[i].a;
            add_b   = atbl[i].b;
            add_cin = atbl[i].cin;
            #1;
            chk($sformatf("adder%0d", i), 32'(add_sum), 32'(atbl[i].s));
        end

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 25; i++)
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].lat);

        // Asynchronous reset partway through a divide
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'h40C00000;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("midop reset rdy", 32'(rdy), 32'd0);
        chk("midop reset result", result, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op("post-reset div", 1'b0, 32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 29);

        // start pulses during DIV_ITER must not disturb the running divide
        @(negedge clk);
        start = 1'b1;
        op    = 1'b0;
        a     = 32'h40C00000;
        b     = 32'h40000000;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 32'h3F800000;
                b     = 32'h40400000;
            end
            if (n == 8) start = 1'b0;
            if (rdy) lat = n;
        end
        chk("busy-start latency", 32'(lat), 32'd29);
        chk("busy-start result", result, 32'h40400000);

        // start held high relaunches once the result is posted
        @(negedge clk);
        start = 1'b1;
        op    = 1'b1;
        a     = 32'h40000000;
        b     = 32'h40800000;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("held start rdy edge4", 32'(rdy), 32'd1);
        chk("held start result edge4", result, 32'h40400000);
        @(posedge clk);
        #1;
        chk("held start relaunch edge5", 32'(rdy), 32'd0);
        start = 1'b0;
        lat   = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(posedge clk);
            #1;
            if (rdy) lat = n;
        end
        chk("relaunch latency", 32'(lat), 32'd4);
        chk("relaunch result", result, 32'h40400000);
        repeat (3) @(posedge clk);
        #1;
        chk("rdy held in DONE", 32'(rdy), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/f32_divmean_unit.md
# f32_divmean_unit

Shared IEEE-754 single-precision arithmetic helper for the square-root engines. It provides a multi-cycle float divide (num/den), a multi-cycle two-operand float mean ((a+b)/2), and a combinational 8-bit exponent adder. It sits beside the sqrt iteration controller, which issues one operation at a time and waits for `rdy`.

## Interface
- No parameters. Widths are fixed: 32-bit float, 8-bit exponent, 23-bit mantissa.
- Clocking: one clock; reset is asynchronous and active-low. Ports are named `clk` and `rst`.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: launch request, sampled on a rising edge.
- `op` in 1: operation select. 0 = divide `a`/`b`; 1 = mean of `a` and `b`. Sampled with `start`.
- `a` in 32: float operand (dividend, or mean input). Captured at `start`.
- `b` in 32: float operand (divisor, or mean input). Captured at `start`.
- `rdy` out 1: result valid. Held high until the next accepted `start`.
- `result` out 32: registered float result.
- `add_a`, `add_b` in 8: exponent adder operands.
- `add_cin` in 1: exponent adder carry-in.
- `add_sum` out 8: `(add_a + add_b + add_cin) mod 256`. Purely combinational, no carry-out. It is used for bias arithmetic, e.g. `exp + 129` equals `exp - 127`.

## Operation
- **State machine:** IDLE, UNPACK, DIV_ITER, ADD, NORM, DONE.
- **Accepting `start`:** in IDLE or DONE, `start=1` captures `op`, `a` and `b`, clears `rdy`, and moves to UNPACK. In any other state `start` is ignored.
- **UNPACK:**
  - Splits both operands into sign, exponent and mantissa with the hidden 1.
  - Denormal inputs are flushed to signed zero.
  - Special cases are resolved here; they go straight to DONE with the result below.
- **Divide, special cases:**
  - Any NaN operand → 0x7FC00000.
  - 0/0 or inf/inf → 0x7FC00000.
  - x/0 with x nonzero, or inf/finite → signed inf.
  - 0/x or finite/inf → signed zero.
  - Result sign is `sa ^ sb`.
- **Divide, normal path:**
  - DIV_ITER runs a restoring division of the 24-bit mantissas: 26 quotient bits, one per cycle, plus a sticky bit from the nonzero remainder.
  - NORM normalises (1-bit left shift if the quotient is below 1).
  - Exponent is `ea - eb + 127`, adjusted by normalisation.
  - Round to nearest, ties to even.
  - Exponent ≥ 255 → signed inf; exponent ≤ 0 → signed zero (flush-to-zero).
- **Mean, special cases:**
  - Any NaN → 0x7FC00000.
  - +inf with -inf → 0x7FC00000.
  - One infinity → that infinity.
- **Mean, normal path:**
  - ADD aligns mantissas (with guard/round/sticky) and adds or subtracts by sign.
  - NORM normalises, subtracts 1 from the exponent (the halving), then rounds to nearest even.
  - The intermediate exponent has one extra bit, so `a+b` never overflows before halving.
  - Exact cancellation gives +0.
  - A result below the normal range flushes to signed zero.
- **DONE:** `result` is registered, `rdy=1`, and both hold until the next accepted `start`.

## Timing
- Reset (`rst=0`, asynchronous): `rdy=0`, `result=0x00000000`, state IDLE, internal registers cleared.
- Reset asserted mid-operation aborts the operation without producing a result.
- Let edge 0 be the edge that accepts `start`. `rdy` falls after edge 0.
- **Divide, normal:** UNPACK on edge 1, DIV_ITER on edges 2–27, NORM on edge 28. `rdy=1` and `result` valid after edge 29.
- **Mean, normal:** UNPACK on edge 1, ADD on edge 2, NORM on edge 3. `rdy=1` after edge 4.
- **Special cases (both ops):** `rdy=1` after edge 2.
- `start` held high in DONE re-launches on every edge at which the unit is back in DONE.
- `a` and `b` may change freely after edge 0.
- `add_sum` has zero latency and is independent of the state machine.

## Test plan
- **Divide, exact:** `a=0x40C00000` (6.0), `b=0x40000000` (2.0), `op=0` → `result=0x40400000`, `rdy` rising after edge 29 exactly.
- **Divide, rounding:** `a=0x3F800000`, `b=0x40400000` → `0x3EAAAAAB`.
- **Divide, specials:**
  - `0x3F800000`/`0x00000000` → `0x7F800000`.
  - `0x00000000`/`0x00000000` → `0x7FC00000`.
  - `0x7F7FFFFF`/`0x00800000` → `0x7F800000`.
  - `rdy` after edge 2 in each case.
- **Mean:**
  - `0x40000000` and `0x40800000` → `0x40400000` after edge 4.
  - `0x7F7FFFFF` with itself → `0x7F7FFFFF` (no overflow).
  - `0x3F800000` and `0xBF800000` → `0x00000000`.
- **Exponent adder:**
  - `add_a=0xC8`, `add_b=0x81`, `add_cin=0` → `add_sum=0x49`.
  - `0xFF + 0x00 + cin 1` → `0x00`.
- **Control:**
  - `rst` pulsed low at cycle 10 of a divide → `rdy=0` and `result=0` immediately.
  - A new `start` then completes normally.
  - `start` during DIV_ITER is ignored; the original result is delivered.
